// File: rtl/stack_pkg.sv
// stack_pkg: shared widths, op codes and front-end FSM states for the LIFO stack.
package stack_pkg;
  localparam int STACK_DATA_WIDTH = 8;
  localparam int STACK_DEPTH = 16;
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/stack_occupancy.sv
// stack_occupancy: registered depth counter with full/empty flags driven by inc/dec strobes.
module stack_occupancy #(
  parameter int DEPTH = 16,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] depth_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [CW-1:0] depth_q, depth_d;
  logic full_q, empty_q;
  always_comb depth_d = inc_i ? depth_q + 1'b1 : dec_i ? depth_q - 1'b1 : depth_q;
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      depth_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      depth_q <= depth_d;
      full_q <= depth_d == CW'(DEPTH);
      empty_q <= depth_d == '0;
    end
  end
  assign depth_o = depth_q;
  assign full_o = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/stack_master.sv
// stack_master: valid/ready front end issuing one push/pop strobe per command to an 8-bit LIFO.
// Define STACK_MASTER_ERR_CHECK_EN to add the sticky mismatch output driven by stk_error.
module stack_master import stack_pkg::*; #(
  parameter int DATA_WIDTH = STACK_DATA_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int POP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic                   cmd_op,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  output logic                   cmd_ready,
  output logic                   rsp_valid,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   rsp_err,
  input  logic                   rsp_ready,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [DATA_WIDTH-1:0]  stk_data_in,
  input  logic [DATA_WIDTH-1:0]  stk_data_out,
  input  logic                   stk_error,
`ifdef STACK_MASTER_ERR_CHECK_EN
  output logic                   mismatch,
`endif
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty
);
  localparam int LW = POP_LAT > 1 ? $clog2(POP_LAT) : 1;
  state_e state_q;
  logic op_q, cmd_ready_q, rsp_valid_q, rsp_err_q, push_q, pop_q;
  logic [DATA_WIDTH-1:0] rsp_data_q, data_in_q;
  logic [LW-1:0] lat_q;
  logic full_w, empty_w;
`ifdef STACK_MASTER_ERR_CHECK_EN
  logic chk_q, mismatch_q;
`else
  logic unused_stk_error;
  assign unused_stk_error = stk_error;
`endif
  stack_occupancy #(.DEPTH(DEPTH), .CW($clog2(DEPTH) + 1)) u_occ (
    .clk(clk), .rst_i(reset), .inc_i(push_q), .dec_i(pop_q),
    .depth_o(depth), .full_o(full_w), .empty_o(empty_w)
  );
  // Strobes are loaded on the IDLE handshake so they are high exactly during ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= OP_PUSH;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_data_q <= '0;
      push_q <= 1'b0;
      pop_q <= 1'b0;
      data_in_q <= '0;
      lat_q <= '0;
`ifdef STACK_MASTER_ERR_CHECK_EN
      chk_q <= 1'b0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      pop_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q <= cmd_op;
          cmd_ready_q <= 1'b0;
          if (cmd_op == OP_PUSH ? full_w : empty_w) begin
            state_q <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q <= 1'b1;
            rsp_data_q <= '0;
          end else begin
            state_q <= ISSUE;
            push_q <= cmd_op == OP_PUSH;
            pop_q <= cmd_op == OP_POP;
            if (cmd_op == OP_PUSH) data_in_q <= cmd_data;
          end
        end
        ISSUE: if (op_q == OP_PUSH) begin
          state_q <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q <= '0;
        end else begin
          state_q <= WAIT;
          lat_q <= LW'(POP_LAT - 1);
        end
        WAIT: if (lat_q == '0) begin
          state_q <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q <= stk_data_out;
        end else begin
          lat_q <= lat_q - 1'b1;
        end
        RESP: if (rsp_ready) begin
          state_q <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
`ifdef STACK_MASTER_ERR_CHECK_EN
      // A stack error right after a legal strobe keeps the response open so the client sees rsp_err.
      chk_q <= push_q | pop_q;
      if (chk_q && stk_error) begin
        mismatch_q <= 1'b1;
        rsp_err_q <= 1'b1;
        if (state_q == RESP) begin
          state_q <= RESP;
          rsp_valid_q <= 1'b1;
          cmd_ready_q <= 1'b0;
        end
      end
`endif
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign stk_push = push_q;
  assign stk_pop = pop_q;
  assign stk_data_in = data_in_q;
  assign full = full_w;
  assign empty = empty_w;
`ifdef STACK_MASTER_ERR_CHECK_EN
  assign mismatch = mismatch_q;
`endif
endmodule
